pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter AW, default 10, program address width.
REQ-002 SHALL have parameter DEPTH, default 8, return-stack entries (power of two, >=2).
REQ-003 SHALL have parameter VECTOR, default 1 (AW bits), interrupt entry address.
REQ-004 SHALL use one clock; reset is asynchronous and active-high. Port clk  in  1  rising-edge clock.
REQ-005 reset  in  1  async active-high reset.
REQ-006 en  in  1  advance one instruction this cycle; 0 = hold all state.
REQ-007 op  in  3  0 NEXT, 1 JUMP, 2 JREL, 3 JZ, 4 JNZ, 5 CALL, 6 RET, 7 RETI.
REQ-008 target  in  AW  absolute address (JUMP/JZ/JNZ/CALL) or two's-complement offset (JREL).
REQ-009 z  in  1  zero flag from datapath.
REQ-010 irq  in  1  level interrupt request.
REQ-011 ie  in  1  interrupt enable.
REQ-012 clr_err  in  1  clears sticky error flags.
REQ-013 pc  out  AW  current program address (registered).
REQ-014 irq_ack  out  1  combinational; interrupt taken this cycle, datapath suppresses side effects of current op.
REQ-015 depth  out  clog2(DEPTH)+1  occupied stack entries.
REQ-016 full, empty  out  1 each  depth==DEPTH, depth==0.
REQ-017 overflow, underflow  out  1 each  sticky errors.
REQ-018 in_isr  out  1  interrupt service in progress.

Function
REQ-019 All state SHALL update only on rising clk with en=1 (except reset and clr_err); en=0 holds pc, stack, flags.
REQ-020 irq_ack SHALL equal en & irq & ie & !in_isr & !full.
REQ-021 On irq_ack: push pc (unincremented, instruction re-executes after RETI), pc<=VECTOR, in_isr<=1; op ignored.
REQ-022 Interrupt with full=1 SHALL be deferred (no ack, no error), op executes normally.
REQ-023 NEXT: pc<=pc+1 modulo 2^AW (wrap 2^AW-1 -> 0).
REQ-024 JUMP: pc<=target.
REQ-025 JREL: pc<=pc+sign-extended target, modulo 2^AW.
REQ-026 JZ: pc<=target if z else pc+1; JNZ: pc<=target if !z else pc+1.
REQ-027 CALL, not full: push pc+1 (wrapped), pc<=target, depth+1.
REQ-028 CALL, full: no push, pc<=pc+1, overflow<=1.
REQ-029 RET, not empty: pc<=top entry, depth-1.
REQ-030 RET, empty: pc<=pc+1, underflow<=1, depth stays 0.
REQ-031 RETI: as RET, plus in_isr<=0; RETI when in_isr=0 behaves exactly as RET.
REQ-032 Stack SHALL be LIFO; only top entry observable via return; entries above depth undefined.
REQ-033 clr_err=1 SHALL clear overflow/underflow next edge regardless of en; a same-cycle new error SHALL win (flag set).
REQ-034 Nested CALLs inside ISR SHALL be allowed; interrupts SHALL not nest (in_isr blocks ack).
REQ-035 Stack push/pop SHALL complete in one cycle; pc change visible the cycle after the edge.

Reset
REQ-036 reset=1 SHALL asynchronously force pc=0, depth=0, empty=1, full=0, overflow=0, underflow=0, in_isr=0, regardless of clk/en; stack contents need not be cleared.
REQ-037 Reset mid-ISR or mid-call-chain SHALL discard all pending returns; first edge after release with en=1, op=NEXT gives pc=1.

Verification
REQ-038 Reset, en=1, op=NEXT x3 -> pc 0,1,2,3; AW=10 with pc=1023, NEXT -> pc=0.
REQ-039 pc=20, JREL target=10'h3FE (-2) -> pc=18; pc=1, JREL -2 -> pc=1023.
REQ-040 pc=5, CALL 100; pc=100, CALL 200; RET; RET -> pc 100,200,101,6; depth 1,2,1,0.
REQ-041 DEPTH=8: 8 CALLs -> full=1; 9th CALL at pc=p -> pc=p+1, overflow=1, depth=8; clr_err -> overflow=0.
REQ-042 pc=40, ie=1, irq=1, op=JUMP 7 -> irq_ack=1, pc=VECTOR, in_isr=1, depth=1; irq held, next cycle no ack; RETI -> pc=40, in_isr=0; with full=1, irq -> no ack.
REQ-043 Empty stack, RET at pc=9 -> pc=10, underflow=1; assert reset between clock edges mid-ISR -> all outputs reset immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- bus between the program-counter sequencer and its controller.
//   Controller -> sequencer : en, op, target, z, irq, ie, clr_err
//   Sequencer -> controller : pc, irq_ack, depth, full, empty,
//                             overflow, underflow, in_isr
// master modport: the controller/datapath side. slave modport: pc_sequencer.
interface pc_sequencer_if #(
  parameter int AW    = 10,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic          en;
  logic [2:0]    op;
  logic [AW-1:0] target;
  logic          z;
  logic          irq;
  logic          ie;
  logic          clr_err;

  logic [AW-1:0] pc;
  logic          irq_ack;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
  logic          in_isr;

  modport master (
    output en, op, target, z, irq, ie, clr_err,
    input  pc, irq_ack, depth, full, empty, overflow, underflow, in_isr
  );

  modport slave (
    input  en, op, target, z, irq, ie, clr_err,
    output pc, irq_ack, depth, full, empty, overflow, underflow, in_isr
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter with a hardware return stack and a single
// non-nesting interrupt level.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : pc_sequencer_if.slave (instruction control in, pc/stack status out)
// Parameters: AW program address width, DEPTH return-stack entries (power of
// two, >= 2), VECTOR interrupt entry address.
module pc_sequencer #(
  parameter int            AW     = 10,
  parameter int            DEPTH  = 8,
  parameter logic [AW-1:0] VECTOR = AW'(1)
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JUMP = 3'd1,
    OP_JREL = 3'd2,
    OP_JZ   = 3'd3,
    OP_JNZ  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_RETI = 3'd7
  } op_e;

  logic [AW-1:0] pc_d, pc_q;
  logic [DW-1:0] depth_d, depth_q;
  logic          overflow_d, overflow_q;
  logic          underflow_d, underflow_q;
  logic          in_isr_d, in_isr_q;

  logic [AW-1:0] stack_q [DEPTH];

  op_e           op_s;
  logic          push_s;
  logic [AW-1:0] push_val_s;
  logic [AW-1:0] pc_inc_s;
  logic [AW-1:0] top_s;
  logic [PW-1:0] push_idx_s;
  logic [PW-1:0] top_idx_s;
  logic          full_s;
  logic          empty_s;
  logic          irq_ack_s;

  assign op_s       = op_e'(bus.op);
  assign pc_inc_s   = pc_q + AW'(1);
  assign full_s     = (depth_q == DW'(DEPTH));
  assign empty_s    = (depth_q == DW'(0));
  // Pushes land at index depth; the top entry sits one below. A push only
  // happens when not full, so depth fits in PW bits at that point.
  assign push_idx_s = depth_q[PW-1:0];
  assign top_idx_s  = PW'(depth_q - DW'(1));
  assign top_s      = stack_q[top_idx_s];
  // A full stack defers the interrupt rather than losing the return address.
  assign irq_ack_s  = bus.en & bus.irq & bus.ie & ~in_isr_q & ~full_s;

  // Next-state: interrupt entry takes priority over the current op.
  always_comb begin
    pc_d        = pc_q;
    depth_d     = depth_q;
    in_isr_d    = in_isr_q;
    overflow_d  = overflow_q & ~bus.clr_err;
    underflow_d = underflow_q & ~bus.clr_err;
    push_s      = 1'b0;
    push_val_s  = pc_q;
    if (irq_ack_s) begin
      // Unincremented pc is saved so the interrupted op re-executes after RETI.
      push_s     = 1'b1;
      push_val_s = pc_q;
      depth_d    = depth_q + DW'(1);
      pc_d       = VECTOR;
      in_isr_d   = 1'b1;
    end else if (bus.en) begin
      case (op_s)
        OP_NEXT: pc_d = pc_inc_s;
        OP_JUMP: pc_d = bus.target;
        // AW-bit add is the same as adding the sign-extended offset mod 2^AW.
        OP_JREL: pc_d = pc_q + bus.target;
        OP_JZ:   pc_d = bus.z ? bus.target : pc_inc_s;
        OP_JNZ:  pc_d = bus.z ? pc_inc_s : bus.target;
        OP_CALL: begin
          if (full_s) begin
            pc_d       = pc_inc_s;
            overflow_d = 1'b1;
          end else begin
            push_s     = 1'b1;
            push_val_s = pc_inc_s;
            depth_d    = depth_q + DW'(1);
            pc_d       = bus.target;
          end
        end
        OP_RET, OP_RETI: begin
          if (empty_s) begin
            pc_d        = pc_inc_s;
            underflow_d = 1'b1;
          end else begin
            pc_d    = top_s;
            depth_d = depth_q - DW'(1);
          end
          if (op_s == OP_RETI) begin
            in_isr_d = 1'b0;
          end else begin
            in_isr_d = in_isr_q;
          end
        end
        default: pc_d = pc_inc_s;
      endcase
    end else begin
      pc_d    = pc_q;
      depth_d = depth_q;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      in_isr_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      in_isr_q    <= in_isr_d;
    end
  end

  // Return-stack storage; contents are don't-care above depth, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_q[push_idx_s] <= push_val_s;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.irq_ack   = irq_ack_s;
  assign bus.depth     = depth_q;
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.in_isr    = in_isr_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed self-checking bench for pc_sequencer
// (AW=10, DEPTH=8, VECTOR=1).
module tb_pc_sequencer;
  localparam int AW    = 10;
  localparam int DEPTH = 8;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, JREL = 3'd2, JZ = 3'd3,
                         JNZ = 3'd4, CALL = 3'd5, RET = 3'd6, RETI = 3'd7;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pc_sequencer_if #(.AW(AW), .DEPTH(DEPTH)) intf ();

  pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .VECTOR(10'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one instruction, clock it, and land 1 time unit after the edge.
  task automatic step(input logic [2:0] op, input logic [9:0] target);
    intf.op     = op;
    intf.target = target;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    intf.en = 1'b1; intf.op = NEXT; intf.target = 10'd0; intf.z = 1'b0;
    intf.irq = 1'b0; intf.ie = 1'b0; intf.clr_err = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pc", intf.pc, 0);
    check_eq("rst_depth", intf.depth, 0);
    check_eq("rst_empty", intf.empty, 1);
    check_eq("rst_full", intf.full, 0);
    check_eq("rst_ovf", intf.overflow, 0);
    check_eq("rst_unf", intf.underflow, 0);
    check_eq("rst_isr", intf.in_isr, 0);
    reset = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 3; i++) begin
      step(NEXT, 10'd0);
      check_eq("next_pc", intf.pc, i);
    end
    intf.en = 1'b0;
    step(NEXT, 10'd0);
    check_eq("hold_pc", intf.pc, 3);
    intf.en = 1'b1;
    step(JUMP, 10'd1023);
    check_eq("jump_pc", intf.pc, 1023);
    step(NEXT, 10'd0);
    check_eq("wrap_pc", intf.pc, 0);

    // Relative jumps
    step(JUMP, 10'd20);
    step(JREL, 10'h3FE);
    check_eq("jrel_20", intf.pc, 18);
    step(JUMP, 10'd1);
    step(JREL, 10'h3FE);
    check_eq("jrel_wrap", intf.pc, 1023);

    // Conditional jumps
    intf.z = 1'b1; step(JZ, 10'd50);  check_eq("jz_taken", intf.pc, 50);
    intf.z = 1'b0; step(JZ, 10'd70);  check_eq("jz_fall", intf.pc, 51);
    intf.z = 1'b0; step(JNZ, 10'd300); check_eq("jnz_taken", intf.pc, 300);
    intf.z = 1'b1; step(JNZ, 10'd500); check_eq("jnz_fall", intf.pc, 301);

    // Call/return chain
    step(JUMP, 10'd5);
    step(CALL, 10'd100); check_eq("call1_pc", intf.pc, 100); check_eq("call1_d", intf.depth, 1);
    step(CALL, 10'd200); check_eq("call2_pc", intf.pc, 200); check_eq("call2_d", intf.depth, 2);
    step(RET, 10'd0);    check_eq("ret1_pc", intf.pc, 101);  check_eq("ret1_d", intf.depth, 1);
    step(RET, 10'd0);    check_eq("ret2_pc", intf.pc, 6);    check_eq("ret2_d", intf.depth, 0);

    // Underflow, clear, and set-wins-over-clear
    step(JUMP, 10'd9);
    step(RET, 10'd0);
    check_eq("unf_pc", intf.pc, 10);
    check_eq("unf_flag", intf.underflow, 1);
    check_eq("unf_depth", intf.depth, 0);
    intf.clr_err = 1'b1;
    step(RET, 10'd0);
    check_eq("unf_setwins", intf.underflow, 1);
    intf.en = 1'b0;
    step(RET, 10'd0);
    check_eq("unf_clr_noen", intf.underflow, 0);
    check_eq("unf_clr_pc", intf.pc, 11);
    intf.clr_err = 1'b0;
    intf.en = 1'b1;

    // Fill the stack, overflow, deferred interrupt
    step(JUMP, 10'd301);
    for (int i = 0; i < DEPTH; i++) begin
      step(CALL, 10'(100 + i));
    end
    check_eq("fill_pc", intf.pc, 107);
    check_eq("fill_full", intf.full, 1);
    check_eq("fill_depth", intf.depth, 8);
    intf.irq = 1'b1; intf.ie = 1'b1; intf.op = CALL; intf.target = 10'd500;
    #1;
    check_eq("full_noack", intf.irq_ack, 0);
    step(CALL, 10'd500);
    check_eq("ovf_pc", intf.pc, 108);
    check_eq("ovf_flag", intf.overflow, 1);
    check_eq("ovf_depth", intf.depth, 8);
    check_eq("ovf_isr", intf.in_isr, 0);
    intf.irq = 1'b0;
    intf.clr_err = 1'b1;
    step(JUMP, 10'd107);
    check_eq("ovf_clr", intf.overflow, 0);
    intf.clr_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step(RET, 10'd0);
      check_eq("unwind_pc", intf.pc, (i < DEPTH - 1) ? 107 - i : 302);
    end
    check_eq("unwind_empty", intf.empty, 1);

    // Interrupt entry, nesting block, nested call, RETI
    step(JUMP, 10'd40);
    intf.ie = 1'b0; intf.irq = 1'b1; intf.op = JUMP; intf.target = 10'd7;
    #1;
    check_eq("ie0_noack", intf.irq_ack, 0);
    intf.ie = 1'b1;
    #1;
    check_eq("irq_ack", intf.irq_ack, 1);
    step(JUMP, 10'd7);
    check_eq("isr_pc", intf.pc, 1);
    check_eq("isr_flag", intf.in_isr, 1);
    check_eq("isr_depth", intf.depth, 1);
    intf.op = NEXT;
    #1;
    check_eq("isr_noack", intf.irq_ack, 0);
    step(NEXT, 10'd0);
    check_eq("isr_next", intf.pc, 2);
    step(CALL, 10'd600);
    check_eq("isr_call", intf.pc, 600);
    check_eq("isr_call_d", intf.depth, 2);
    step(RET, 10'd0);
    check_eq("isr_ret", intf.pc, 3);
    intf.irq = 1'b0;
    step(RETI, 10'd0);
    check_eq("reti_pc", intf.pc, 40);
    check_eq("reti_isr", intf.in_isr, 0);
    check_eq("reti_depth", intf.depth, 0);

    // Asynchronous reset in the middle of an ISR with a pending call
    intf.irq = 1'b1;
    step(NEXT, 10'd0);
    intf.irq = 1'b0;
    step(CALL, 10'd77);
    check_eq("mid_depth", intf.depth, 2);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_pc", intf.pc, 0);
    check_eq("arst_depth", intf.depth, 0);
    check_eq("arst_isr", intf.in_isr, 0);
    check_eq("arst_empty", intf.empty, 1);
    #1;
    reset = 1'b0;
    step(NEXT, 10'd0);
    check_eq("post_rst_pc", intf.pc, 1);
    step(RET, 10'd0);
    check_eq("post_rst_ret", intf.pc, 2);
    check_eq("post_rst_unf", intf.underflow, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
